// File: rtl/axis_pack.sv
// Narrow-to-wide AXI-Stream packer: gathers RATIO input lanes LSB-first into one
// output word; s_axi_tlast closes a partial word early, m_axi_tkeep marks the filled lanes.
module axis_pack #(
    parameter int IN_BITS = 8,
    parameter int RATIO   = 4
) (
    input  logic                       axi_clk,
    input  logic                       axi_resetn,
    input  logic                       s_axi_tvalid,
    output logic                       s_axi_tready,
    input  logic [IN_BITS-1:0]         s_axi_tdata,
    input  logic                       s_axi_tlast,
    output logic                       m_axi_tvalid,
    input  logic                       m_axi_tready,
    output logic [IN_BITS*RATIO-1:0]   m_axi_tdata,
    output logic [RATIO-1:0]           m_axi_tkeep,
    output logic                       m_axi_tlast
);
    localparam int OUT_BITS = IN_BITS * RATIO;
    localparam int IDX_W    = $clog2(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    logic [IDX_W-1:0]    idx;
    logic [OUT_BITS-1:0] acc;
    logic [OUT_BITS-1:0] acc_next;
    logic [RATIO-1:0]    keep;
    logic [RATIO-1:0]    keep_next;
    logic                accept;
    logic                closing;

    // Handshake: a beat/word moves on a clock edge where valid && ready are both high.
    // Input ready is combinational: the output register can take a new word when it is
    // empty or is being drained this cycle.
    assign s_axi_tready = !m_axi_tvalid || m_axi_tready;
    assign accept       = s_axi_tvalid && s_axi_tready;
    assign closing      = (idx == LAST_IDX) || s_axi_tlast;

    // Accumulator with the incoming beat merged into lane idx.
    always_comb begin
        acc_next  = acc;
        keep_next = keep;
        for (int k = 0; k < RATIO; k++) begin
            if (idx == IDX_W'(k)) begin
                acc_next[k*IN_BITS +: IN_BITS] = s_axi_tdata;
                keep_next[k]                   = 1'b1;
            end
        end
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            idx  <= '0;
            acc  <= '0;
            keep <= '0;
        end else if (accept) begin
            if (closing) begin
                idx  <= '0;
                acc  <= '0;
                keep <= '0;
            end else begin
                idx  <= idx + 1'b1;
                acc  <= acc_next;
                keep <= keep_next;
            end
        end
    end

    // Output register: a new closing beat wins over draining, so a word consumed in
    // the same cycle a new one closes leaves m_axi_tvalid high.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            m_axi_tvalid <= 1'b0;
            m_axi_tdata  <= '0;
            m_axi_tkeep  <= '0;
            m_axi_tlast  <= 1'b0;
        end else if (accept && closing) begin
            m_axi_tvalid <= 1'b1;
            m_axi_tdata  <= acc_next;
            m_axi_tkeep  <= keep_next;
            m_axi_tlast  <= s_axi_tlast;
        end else if (m_axi_tvalid && m_axi_tready) begin
            m_axi_tvalid <= 1'b0;
            m_axi_tdata  <= '0;
            m_axi_tkeep  <= '0;
            m_axi_tlast  <= 1'b0;
        end
    end

endmodule
